deser_align_ctrl: RTL

Word-alignment controller for the 5-bit sliding-window LVDS deserializer on the F2F RX path. The deserializer shifts one bit per clock and has no notion of word boundaries. This block tracks a modulo-5 bit phase, searches the window for a training pattern, and confirms the match on consecutive frames before declaring lock. Once locked, it emits one framed 5-bit word every 5 clocks to the RX link layer, and it supports re-alignment on request or on search timeout.

---
 rtl/deser_align_ctrl.sv | 203 ++++++++++++++++++++
 1 files changed

// File: rtl/deser_align_ctrl.sv
// -----------------------------------------------------------------------------
// deser_align_ctrl
//
// Word-alignment controller for a 5-bit sliding-window deserializer. The
// deserializer shifts in one bit per clock, so every clock presents a new
// 5-bit window. This block tracks a modulo-5 bit phase and looks for the
// training symbol in the window. It then confirms the match on consecutive
// frames at the same phase. Once locked, it frames one 5-bit word every 5
// clocks.
//
// Ports
//   clk          : single clock, shared with the deserializer
//   reset        : synchronous, active-high
//   data_i       : deserializer window, bit 0 is the newest bit
//   realign_i    : single-cycle request to drop lock and search again
//   word_o       : framed word (holds its last value between strobes)
//   word_valid_o : one-cycle strobe qualifying word_o
//   locked_o     : high while in LOCKED
//   phase_o      : phase the current lock was acquired at (0..4)
//   timeout_o    : one-cycle pulse when a search/confirm attempt times out
//
// All outputs are registered. A decision made on the window in cycle N
// is visible on the outputs in cycle N+1.
// -----------------------------------------------------------------------------
module deser_align_ctrl #(
  parameter logic [4:0] TRAIN_PATTERN  = 5'b00111,
  parameter int         MATCH_COUNT    = 4,
  parameter int         TIMEOUT_CYCLES = 1024
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] data_i,
  input  logic       realign_i,
  output logic [4:0] word_o,
  output logic       word_valid_o,
  output logic       locked_o,
  output logic [2:0] phase_o,
  output logic       timeout_o
);

  localparam int MW = $clog2(MATCH_COUNT + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES);

  localparam logic [MW-1:0] MATCH_ONE  = MW'(1);
  localparam logic [MW-1:0] MATCH_FULL = MW'(MATCH_COUNT);
  localparam logic [TW-1:0] TMO_ONE    = TW'(1);
  localparam logic [TW-1:0] TMO_LAST   = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [2:0]    PH_LAST    = 3'd4;
  // Six flush cycles (count 0..5) let the window fill with fresh bits.
  localparam logic [2:0]    FLUSH_LAST = 3'd5;

  typedef enum logic [1:0] {
    FLUSH   = 2'd0,
    SEARCH  = 2'd1,
    CONFIRM = 2'd2,
    LOCKED  = 2'd3
  } state_t;

  state_t        state_reg, state_next;
  logic [2:0]    ph_reg, ph_next;
  logic [2:0]    lock_ph_reg, lock_ph_next;
  logic [2:0]    flush_cnt_reg, flush_cnt_next;
  logic [MW-1:0] match_cnt_reg, match_cnt_next;
  logic [TW-1:0] tmo_cnt_reg, tmo_cnt_next;

  logic [4:0]    word_next;
  logic          word_valid_next;
  logic          locked_next;
  logic [2:0]    phase_next;
  logic          timeout_next;

  logic          pattern_hit;
  logic          on_phase;
  logic          hunting;
  logic [MW-1:0] match_cnt_inc;

  assign pattern_hit   = (data_i == TRAIN_PATTERN);
  assign on_phase      = (ph_reg == lock_ph_reg);
  assign hunting       = (state_reg == SEARCH) || (state_reg == CONFIRM);
  assign match_cnt_inc = match_cnt_reg + MATCH_ONE;

  // ---------------------------------------------------------------------------
  // Next-state and output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next      = state_reg;
    ph_next         = (ph_reg == PH_LAST) ? 3'd0 : ph_reg + 3'd1;
    lock_ph_next    = lock_ph_reg;
    flush_cnt_next  = flush_cnt_reg;
    match_cnt_next  = match_cnt_reg;
    tmo_cnt_next    = tmo_cnt_reg;
    word_next       = word_o;
    word_valid_next = 1'b0;
    phase_next      = phase_o;
    timeout_next    = 1'b0;
    locked_next     = 1'b0;

    case (state_reg)
      FLUSH: begin
        if (flush_cnt_reg == FLUSH_LAST) begin
          flush_cnt_next = 3'd0;
          state_next     = SEARCH;
        end else begin
          flush_cnt_next = flush_cnt_reg + 3'd1;
        end
      end

      SEARCH: begin
        tmo_cnt_next = tmo_cnt_reg + TMO_ONE;
        if (pattern_hit) begin
          lock_ph_next   = ph_reg;
          match_cnt_next = MATCH_ONE;
          state_next     = CONFIRM;
        end
      end

      CONFIRM: begin
        tmo_cnt_next = tmo_cnt_reg + TMO_ONE;
        // Only the window at the candidate phase carries a whole symbol.
        if (on_phase) begin
          if (pattern_hit) begin
            match_cnt_next = match_cnt_inc;
            if (match_cnt_inc == MATCH_FULL) begin
              state_next   = LOCKED;
              tmo_cnt_next = '0;
            end
          end else begin
            // The failing window is dropped, not re-tried as a new SEARCH hit.
            match_cnt_next = '0;
            state_next     = SEARCH;
          end
        end
      end

      LOCKED: begin
        if (on_phase) begin
          word_next       = data_i;
          word_valid_next = 1'b1;
        end
      end

      default: begin
        state_next = FLUSH;
      end
    endcase

    // Realign outranks the normal transitions above. It also suppresses a
    // word that would otherwise be framed in the same cycle.
    if (realign_i && ((state_reg == CONFIRM) || (state_reg == LOCKED))) begin
      state_next      = SEARCH;
      match_cnt_next  = '0;
      tmo_cnt_next    = '0;
      word_next       = word_o;
      word_valid_next = 1'b0;
    end

    // A timeout outranks realign. It also outranks a final confirming match
    // in the same cycle, so the attempt ends without lock.
    if (hunting && (tmo_cnt_reg == TMO_LAST)) begin
      timeout_next   = 1'b1;
      tmo_cnt_next   = '0;
      match_cnt_next = '0;
      state_next     = SEARCH;
    end

    locked_next = (state_next == LOCKED);
    if (state_next == LOCKED) begin
      phase_next = lock_ph_next;
    end
  end

  // ---------------------------------------------------------------------------
  // State and output registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= FLUSH;
      ph_reg        <= 3'd0;
      lock_ph_reg   <= 3'd0;
      flush_cnt_reg <= 3'd0;
      match_cnt_reg <= '0;
      tmo_cnt_reg   <= '0;
      word_o        <= 5'd0;
      word_valid_o  <= 1'b0;
      locked_o      <= 1'b0;
      phase_o       <= 3'd0;
      timeout_o     <= 1'b0;
    end else begin
      state_reg     <= state_next;
      ph_reg        <= ph_next;
      lock_ph_reg   <= lock_ph_next;
      flush_cnt_reg <= flush_cnt_next;
      match_cnt_reg <= match_cnt_next;
      tmo_cnt_reg   <= tmo_cnt_next;
      word_o        <= word_next;
      word_valid_o  <= word_valid_next;
      locked_o      <= locked_next;
      phase_o       <= phase_next;
      timeout_o     <= timeout_next;
    end
  end

endmodule
